pipeline_hazard_ctrl: RTL



---
 rtl/pipeline_hazard_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and end-of-program sequencer for a five-stage MIPS pipeline: load-use stalls,
// redirect flushes, halt/drain/dump handshake. Performance counters exist only with `PIPE_HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
   parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic [31:0] i_if_id_instr,
   input  logic        i_id_ex_memread,
   input  logic [4:0]  i_id_ex_rt,
   input  logic        i_ex_redirect,
   input  logic        i_dump_ack,
   output logic        o_pc_write,
   output logic        o_if_id_write,
   output logic        o_if_id_flush,
   output logic        o_id_ex_bubble,
   output logic        o_dump_req,
   output logic        o_done,
   output logic [31:0] o_cycle_count,
   output logic [31:0] o_stall_count
);

   localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_DUMP   = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [DCW-1:0] r_drain_cnt;
   logic [DCW-1:0] w_drain_nxt;

   logic [5:0] w_opcode;
   logic [4:0] w_rs;
   logic [4:0] w_rt;
   logic       w_is_halt;
   logic       w_rt_is_src;
   logic       w_load_use;

   logic w_pc_write;
   logic w_if_id_write;
   logic w_if_id_flush;
   logic w_id_ex_bubble;
   logic w_dump_req;
   logic w_done;

   assign w_opcode  = i_if_id_instr[31:26];
   assign w_rs      = i_if_id_instr[25:21];
   assign w_rt      = i_if_id_instr[20:16];
   assign w_is_halt = (i_if_id_instr == HALT_WORD);

   // Source-register decode and load-use match; the halt word reads no registers.
   always_comb begin
      w_rt_is_src = 1'b0;
      w_load_use  = 1'b0;
      case (w_opcode)
         6'h00, 6'h04, 6'h05, 6'h2B: w_rt_is_src = 1'b1;
         default:                    w_rt_is_src = 1'b0;
      endcase
      if (i_id_ex_memread && (i_id_ex_rt != 5'd0) && !w_is_halt) begin
         if (w_rs == i_id_ex_rt) begin
            w_load_use = 1'b1;
         end else if (w_rt_is_src && (w_rt == i_id_ex_rt)) begin
            w_load_use = 1'b1;
         end else begin
            w_load_use = 1'b0;
         end
      end else begin
         w_load_use = 1'b0;
      end
   end

   // Next-state and per-cycle pipeline controls; frozen-with-bubble is the baseline.
   always_comb begin
      w_state_nxt    = r_state;
      w_drain_nxt    = r_drain_cnt;
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_if_id_flush  = 1'b0;
      w_id_ex_bubble = 1'b1;
      w_dump_req     = 1'b0;
      w_done         = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (i_ex_redirect) begin
               // IF/ID holds wrong-path code, so its halt/hazard status is meaningless.
               w_pc_write    = 1'b1;
               w_if_id_write = 1'b1;
               w_if_id_flush = 1'b1;
            end else if (w_load_use) begin
               w_state_nxt = ST_RUN;
            end else if (w_is_halt) begin
               w_drain_nxt = DRAIN_LOAD;
               w_state_nxt = ST_DRAIN;
            end else begin
               w_pc_write     = 1'b1;
               w_if_id_write  = 1'b1;
               w_id_ex_bubble = 1'b0;
            end
         end
         ST_DRAIN: begin
            if (r_drain_cnt == {DCW{1'b0}}) begin
               w_state_nxt = ST_DUMP;
            end else begin
               w_drain_nxt = r_drain_cnt - DCW'(1);
            end
         end
         ST_DUMP: begin
            w_dump_req = 1'b1;
            if (i_dump_ack) begin
               w_state_nxt = ST_HALTED;
            end else begin
               w_state_nxt = ST_DUMP;
            end
         end
         ST_HALTED: begin
            w_done = 1'b1;
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   // State and drain counter.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= ST_RUN;
         r_drain_cnt <= {DCW{1'b0}};
      end else begin
         r_state     <= w_state_nxt;
         r_drain_cnt <= w_drain_nxt;
      end
   end

   // Controls are combinational, so reset must force them directly, not only via the state.
   assign o_pc_write     = w_pc_write    & i_reset_n;
   assign o_if_id_write  = w_if_id_write & i_reset_n;
   assign o_if_id_flush  = w_if_id_flush & i_reset_n;
   assign o_id_ex_bubble = w_id_ex_bubble | ~i_reset_n;
   assign o_dump_req     = w_dump_req    & i_reset_n;
   assign o_done         = w_done        & i_reset_n;

`ifdef PIPE_HAZARD_PERF_EN
   logic        w_count_evt;
   logic        w_stall_evt;
   logic [31:0] r_cycle_count;
   logic [31:0] r_stall_count;

   assign w_count_evt = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign w_stall_evt = (r_state == ST_RUN) && !i_ex_redirect && w_load_use;

   // Saturating cycle and stall counters.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cycle_count <= 32'd0;
         r_stall_count <= 32'd0;
      end else begin
         if (w_count_evt && (r_cycle_count != 32'hFFFF_FFFF)) begin
            r_cycle_count <= r_cycle_count + 32'd1;
         end else begin
            r_cycle_count <= r_cycle_count;
         end
         if (w_stall_evt && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
         end else begin
            r_stall_count <= r_stall_count;
         end
      end
   end

   assign o_cycle_count = r_cycle_count;
   assign o_stall_count = r_stall_count;
`else
   assign o_cycle_count = 32'd0;
   assign o_stall_count = 32'd0;
`endif

endmodule
